// File: rtl/shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : shift_engine
// Description : Frame shift engine for the SPI controller datapath.
//               A WIDTH-bit word is loaded via a valid/ready handshake and
//               shifted out one bit per strobe (MSB- or LSB-first). Received
//               bits fill the vacated positions. The finished word is
//               presented on o_data with a one-cycle o_data_valid pulse.
// Ports       : i_clk, i_rst          clock, synchronous active-high reset
//               i_load_valid/o_load_ready/i_load_data/i_lsb_first  load side
//               i_shift_en, i_serial   bit strobe and received bit
//               i_abort                abandon the frame in flight
//               o_serial               registered transmit bit
//               o_data, o_data_valid   received word and its update pulse
//               o_busy, o_bit_count    frame status
// Revision    : 1.0  initial release
// ============================================================================
module shift_engine #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_load_valid,
    output logic                       o_load_ready,
    input  logic [WIDTH-1:0]           i_load_data,
    input  logic                       i_lsb_first,
    input  logic                       i_shift_en,
    input  logic                       i_serial,
    input  logic                       i_abort,
    output logic                       o_serial,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_data_valid,
    output logic                       o_busy,
    output logic [$clog2(WIDTH+1)-1:0] o_bit_count
);

    localparam int                c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [WIDTH-1:0]     r_sr,     w_sr_nxt;
    logic                 r_lsb,    w_lsb_nxt;
    logic [c_cnt_w-1:0]   r_count,  w_count_nxt;
    logic                 r_serial, w_serial_nxt;
    logic [WIDTH-1:0]     r_data,   w_data_nxt;
    logic                 r_valid,  w_valid_nxt;

    // Shift register contents after one strobe in the latched direction.
    logic [WIDTH-1:0]     w_shifted;
    // Bit that reaches the output end after this strobe.
    logic                 w_next_out;

    always_comb begin
        if (r_lsb) begin
            w_shifted  = {i_serial, r_sr[WIDTH-1:1]};
            w_next_out = r_sr[1];
        end else begin
            w_shifted  = {r_sr[WIDTH-2:0], i_serial};
            w_next_out = r_sr[WIDTH-2];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sr_nxt     = r_sr;
        w_lsb_nxt    = r_lsb;
        w_count_nxt  = r_count;
        w_serial_nxt = r_serial;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_load_valid) begin
                    w_state_nxt  = S_SHIFT;
                    w_sr_nxt     = i_load_data;
                    w_lsb_nxt    = i_lsb_first;
                    w_count_nxt  = '0;
                    w_serial_nxt = i_lsb_first ? i_load_data[0] : i_load_data[WIDTH-1];
                end
            end
            S_SHIFT: begin
                // Abort has priority, including over the final strobe.
                if (i_abort) begin
                    w_state_nxt  = S_IDLE;
                    w_count_nxt  = '0;
                    w_serial_nxt = IDLE_LEVEL;
                end else if (i_shift_en) begin
                    w_sr_nxt = w_shifted;
                    if (r_count == c_last) begin
                        w_state_nxt  = S_IDLE;
                        w_count_nxt  = '0;
                        w_serial_nxt = IDLE_LEVEL;
                        w_data_nxt   = w_shifted;
                        w_valid_nxt  = 1'b1;
                    end else begin
                        w_count_nxt  = r_count + c_one;
                        w_serial_nxt = w_next_out;
                    end
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_count_nxt  = '0;
                w_serial_nxt = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_lsb    <= 1'b0;
            r_count  <= '0;
            r_serial <= IDLE_LEVEL;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sr     <= w_sr_nxt;
            r_lsb    <= w_lsb_nxt;
            r_count  <= w_count_nxt;
            r_serial <= w_serial_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    assign o_load_ready = (r_state == S_IDLE);
    assign o_busy       = (r_state == S_SHIFT);
    assign o_serial     = r_serial;
    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_bit_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_engine
// Description : Directed self-checking bench for shift_engine. One instance
//               at WIDTH=8/IDLE_LEVEL=0, one at WIDTH=16/IDLE_LEVEL=1.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shift_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=8 instance signals
    logic       lv8, rdy8, lsb8, en8, si8, ab8, so8, val8, busy8;
    logic [7:0] ld8, d8;
    logic [3:0] cnt8;

    // WIDTH=16 instance signals
    logic        lv16, rdy16, lsb16, en16, si16, ab16, so16, val16, busy16;
    logic [15:0] ld16, d16;
    logic [4:0]  cnt16;

    int errors = 0;
    int checks = 0;

    shift_engine #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_dut8 (
        .i_clk(clk), .i_rst(rst),
        .i_load_valid(lv8), .o_load_ready(rdy8), .i_load_data(ld8), .i_lsb_first(lsb8),
        .i_shift_en(en8), .i_serial(si8), .i_abort(ab8),
        .o_serial(so8), .o_data(d8), .o_data_valid(val8), .o_busy(busy8), .o_bit_count(cnt8)
    );

    shift_engine #(.WIDTH(16), .IDLE_LEVEL(1'b1)) u_dut16 (
        .i_clk(clk), .i_rst(rst),
        .i_load_valid(lv16), .o_load_ready(rdy16), .i_load_data(ld16), .i_lsb_first(lsb16),
        .i_shift_en(en16), .i_serial(si16), .i_abort(ab16),
        .o_serial(so16), .o_data(d16), .o_data_valid(val16), .o_busy(busy16), .o_bit_count(cnt16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift a full 8-bit frame on the WIDTH=8 instance. tx is the loaded word,
    // rx the word to return; with loop set, i_serial is fed from o_serial.
    // gap idle cycles follow each strobe, during which busy must stay high.
    task automatic frame8(input string tag, input logic [7:0] tx, input logic [7:0] rx,
                          input logic lsb, input bit loop, input int gap);
        int idx;
        for (int i = 0; i < 8; i++) begin
            idx = lsb ? i : 7 - i;
            chk({tag, "_serial"}, 32'(so8), 32'(tx[idx]));
            chk({tag, "_count"},  32'(cnt8), 32'(i));
            si8 = loop ? so8 : rx[idx];
            en8 = 1'b1;
            if (i == 7) lv8 = 1'b0;
            tick();
            en8 = 1'b0;
            if (i < 7) begin
                chk({tag, "_novalid"}, 32'(val8), 32'd0);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk({tag, "_gapbusy"}, 32'(busy8), 32'd1);
                    chk({tag, "_gapcount"}, 32'(cnt8), 32'(i + 1));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        lv8 = 0; ld8 = '0; lsb8 = 0; en8 = 0; si8 = 0; ab8 = 0;
        lv16 = 0; ld16 = '0; lsb16 = 0; en16 = 0; si16 = 0; ab16 = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset values
        chk("rst_ready", 32'(rdy8), 32'd1);
        chk("rst_busy",  32'(busy8), 32'd0);
        chk("rst_serial", 32'(so8), 32'd0);
        chk("rst_data",  32'(d8), 32'd0);
        chk("rst_valid", 32'(val8), 32'd0);
        chk("rst_count", 32'(cnt8), 32'd0);
        chk("rst_serial16", 32'(so16), 32'd1);

        // Reset mid-frame: 3 strobes, then reset held 2 cycles with strobes running
        lv8 = 1; ld8 = 8'hA5; lsb8 = 0;
        tick();
        lv8 = 0;
        en8 = 1; si8 = 1;
        tick(); tick(); tick();
        chk("midrst_count3", 32'(cnt8), 32'd3);
        rst = 1;
        tick();
        chk("midrst_valid_a", 32'(val8), 32'd0);
        tick();
        rst = 0; en8 = 0;
        chk("midrst_busy",  32'(busy8), 32'd0);
        chk("midrst_ready", 32'(rdy8), 32'd1);
        chk("midrst_count", 32'(cnt8), 32'd0);
        chk("midrst_serial", 32'(so8), 32'd0);
        chk("midrst_data",  32'(d8), 32'd0);
        chk("midrst_valid", 32'(val8), 32'd0);
        tick();
        chk("midrst_valid_b", 32'(val8), 32'd0);

        // MSB-first loopback of 0xA5, back-to-back strobes
        lv8 = 1; ld8 = 8'hA5; lsb8 = 0;
        tick();
        lv8 = 0;
        chk("msb_busy",  32'(busy8), 32'd1);
        chk("msb_ready", 32'(rdy8), 32'd0);
        frame8("msb", 8'hA5, 8'hA5, 1'b0, 1'b1, 0);
        chk("msb_valid",  32'(val8), 32'd1);
        chk("msb_data",   32'(d8), 32'hA5);
        chk("msb_ready_v", 32'(rdy8), 32'd1);
        chk("msb_idle_serial", 32'(so8), 32'd0);
        chk("msb_count_wrap", 32'(cnt8), 32'd0);
        tick();
        chk("msb_valid_pulse", 32'(val8), 32'd0);
        chk("msb_data_hold", 32'(d8), 32'hA5);

        // LSB-first: transmit 0x3C, receive 0xC3; lsb toggled mid-frame has no effect
        lv8 = 1; ld8 = 8'h3C; lsb8 = 1;
        tick();
        lv8 = 0; lsb8 = 0;
        frame8("lsb", 8'h3C, 8'hC3, 1'b1, 1'b0, 0);
        chk("lsb_valid", 32'(val8), 32'd1);
        chk("lsb_data",  32'(d8), 32'hC3);
        chk("lsb_count_wrap", 32'(cnt8), 32'd0);
        tick();

        // Gapped strobes, load request held high through the frame
        lv8 = 1; ld8 = 8'hA5; lsb8 = 0;
        tick();
        ld8 = 8'h00;
        frame8("gap", 8'hA5, 8'hA5, 1'b0, 1'b1, 2);
        chk("gap_valid", 32'(val8), 32'd1);
        chk("gap_data",  32'(d8), 32'hA5);
        tick();
        chk("gap_single_load", 32'(busy8), 32'd0);

        // Abort together with the 5th strobe
        lv8 = 1; ld8 = 8'hFF; lsb8 = 0;
        tick();
        lv8 = 0; si8 = 0; en8 = 1;
        tick(); tick(); tick(); tick();
        chk("abort_count4", 32'(cnt8), 32'd4);
        ab8 = 1;
        tick();
        ab8 = 0; en8 = 0;
        chk("abort_busy",  32'(busy8), 32'd0);
        chk("abort_ready", 32'(rdy8), 32'd1);
        chk("abort_count", 32'(cnt8), 32'd0);
        chk("abort_serial", 32'(so8), 32'd0);
        chk("abort_valid", 32'(val8), 32'd0);
        chk("abort_data",  32'(d8), 32'hA5);

        // Abort on the final strobe wins over completion
        lv8 = 1; ld8 = 8'h0F; lsb8 = 0;
        tick();
        lv8 = 0; si8 = 1; en8 = 1;
        for (int i = 0; i < 7; i++) tick();
        chk("abortlast_count7", 32'(cnt8), 32'd7);
        ab8 = 1;
        tick();
        ab8 = 0; en8 = 0;
        chk("abortlast_valid", 32'(val8), 32'd0);
        chk("abortlast_data",  32'(d8), 32'hA5);
        chk("abortlast_busy",  32'(busy8), 32'd0);

        // WIDTH=16, IDLE_LEVEL=1: 0x1234 loopback, then reload in the valid cycle
        chk("w16_idle_serial", 32'(so16), 32'd1);
        lv16 = 1; ld16 = 16'h1234; lsb16 = 0;
        tick();
        lv16 = 0;
        for (int i = 0; i < 16; i++) begin
            chk("w16_serial", 32'(so16), 32'(ld16[15 - i]));
            si16 = so16;
            en16 = 1;
            tick();
        end
        en16 = 0;
        chk("w16_valid", 32'(val16), 32'd1);
        chk("w16_data",  32'(d16), 32'h1234);
        chk("w16_ready", 32'(rdy16), 32'd1);
        chk("w16_idle_after", 32'(so16), 32'd1);
        lv16 = 1; ld16 = 16'h5A5A;
        tick();
        lv16 = 0;
        chk("w16_reload_busy",   32'(busy16), 32'd1);
        chk("w16_reload_serial", 32'(so16), 32'd0);
        chk("w16_reload_valid",  32'(val16), 32'd0);
        ab16 = 1;
        tick();
        ab16 = 0;
        chk("w16_abort_serial", 32'(so16), 32'd1);
        chk("w16_abort_data",   32'(d16), 32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
